// File: rtl/beta_pkg.sv
// Shared constants and types for the BETA register file.
package beta_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam reg_addr_t XP_ADDR   = reg_addr_t'(30);
    localparam reg_addr_t ZERO_ADDR = reg_addr_t'(31);
endpackage

// File: rtl/beta_regfile_rdport.sv
// One combinational read port: R31 reads as zero.
// When REGFILE_BYPASS_EN is defined, a same-cycle write to the addressed register is forwarded.
module beta_regfile_rdport
    import beta_pkg::*;
(
    input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
    input  reg_addr_t                       addr,
`ifdef REGFILE_BYPASS_EN
    input  logic                            byp_en,
    input  reg_addr_t                       wa,
    input  word_t                           wdata,
`endif
    output word_t                           rdata
);

    always_comb begin
        rdata = (addr == ZERO_ADDR) ? '0 : regs[addr];
`ifdef REGFILE_BYPASS_EN
        // byp_en already excludes R31 and reset, so forwarding cannot leak into R31
        if (byp_en && (addr == wa)) rdata = wdata;
`endif
    end

endmodule

// File: rtl/beta_regfile.sv
// BETA 32x32 register file: two combinational read ports, one synchronous write port.
// Optional write-through bypass is built when REGFILE_BYPASS_EN is defined.
module beta_regfile
    import beta_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              RA2SEL,
    input  logic              WASEL,
    input  logic              WERF,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    input  logic [ADDR_W-1:0] RC,
    input  logic [DATA_W-1:0] WDATA,
    output logic [DATA_W-1:0] RADATA,
    output logic [DATA_W-1:0] RBDATA
);

    localparam int NUM_STORED = NUM_REGS - 1;

    logic [NUM_STORED-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0][DATA_W-1:0]   rd_view;
    reg_addr_t                         rb_addr;
    reg_addr_t                         wa;

    assign rb_addr = RA2SEL ? RC : RB;
    assign wa      = WASEL ? XP_ADDR : RC;

    // R31 has no storage; it is padded in as a constant zero for the read muxes
    assign rd_view = {word_t'('0), regs_q};

    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NUM_STORED; i++) begin
            if (WERF && (wa == reg_addr_t'(i))) regs_d[i] = WDATA;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) regs_q <= '0;
        else        regs_q <= regs_d;
    end

`ifdef REGFILE_BYPASS_EN
    logic byp_en;
    assign byp_en = RST_N && WERF && (wa != ZERO_ADDR);
`endif

    beta_regfile_rdport u_rd_a (
        .regs  (rd_view),
        .addr  (RA),
`ifdef REGFILE_BYPASS_EN
        .byp_en(byp_en),
        .wa    (wa),
        .wdata (WDATA),
`endif
        .rdata (RADATA)
    );

    beta_regfile_rdport u_rd_b (
        .regs  (rd_view),
        .addr  (rb_addr),
`ifdef REGFILE_BYPASS_EN
        .byp_en(byp_en),
        .wa    (wa),
        .wdata (WDATA),
`endif
        .rdata (RBDATA)
    );

endmodule

// File: tb/tb_beta_regfile.sv
// Self-checking bench for beta_regfile: directed plan followed by random traffic
// against an array-based reference model.
module tb_beta_regfile;
    import beta_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        RA2SEL = 1'b0, WASEL = 1'b0, WERF = 1'b0;
    logic [4:0]  RA = '0, RB = '0, RC = '0;
    logic [31:0] WDATA = '0;
    logic [31:0] RADATA, RBDATA;

    int checks = 0;
    int errors = 0;
    logic [31:0] mdl [32];

    beta_regfile dut (
        .CLK(CLK), .RST_N(RST_N), .RA2SEL(RA2SEL), .WASEL(WASEL), .WERF(WERF),
        .RA(RA), .RB(RB), .RC(RC), .WDATA(WDATA), .RADATA(RADATA), .RBDATA(RBDATA)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference read: register contents, R31 = 0, optional same-cycle forwarding.
    function automatic logic [31:0] ref_rd(input logic [4:0] a);
        logic [4:0] w;
        w = WASEL ? 5'd30 : RC;
`ifdef REGFILE_BYPASS_EN
        if (RST_N && WERF && w != 5'd31 && a == w) return WDATA;
`endif
        if (a == 5'd31) return 32'd0;
        return mdl[a];
    endfunction

    // Clock edge plus model update, then settle past the edge.
    task automatic tick();
        logic [4:0] w;
        w = WASEL ? 5'd30 : RC;
        @(posedge CLK);
        if (RST_N && WERF && w != 5'd31) mdl[w] = WDATA;
        #1;
    endtask

    task automatic chk_both(input string tag);
        #1;
        chk({tag, "_a"}, RADATA, ref_rd(RA));
        chk({tag, "_b"}, RBDATA, ref_rd(RA2SEL ? RC : RB));
    endtask

    initial begin
        foreach (mdl[i]) mdl[i] = '0;
        #12;
        RA = 5'd31; RB = 5'd31; #1;
        chk("rst_r31_a", RADATA, 32'd0);
        chk("rst_r31_b", RBDATA, 32'd0);
        RA = 5'd5; #1;
        chk("rst_r5", RADATA, 32'd0);
        RST_N = 1'b1;
        @(negedge CLK);

        // Fill R1..R30 with their own index
        for (int n = 1; n <= 30; n++) begin
            WERF = 1'b1; WASEL = 1'b0; RC = 5'(n); WDATA = 32'(n);
            tick();
            WERF = 1'b0; RA = 5'(n); RB = 5'(n - 1); #1;
            chk("fill_a", RADATA, 32'(n));
            chk("fill_b", RBDATA, 32'(n - 1));
        end

        WERF = 1'b1; RC = 5'd31; WDATA = 32'd31; tick();
        WERF = 1'b0; RA = 5'd31; #1;
        chk("r31_discard", RADATA, 32'd0);
        WERF = 1'b0; RC = 5'd5; WDATA = 32'd0; tick();
        RA = 5'd5; #1;
        chk("werf0_hold", RADATA, 32'd5);

        RA2SEL = 1'b1; RA = 5'd1; RB = 5'd2; RC = 5'd3; #1;
        chk("ra2sel_a", RADATA, 32'd1);
        chk("ra2sel_b", RBDATA, 32'd3);
        RC = 5'd31; #1;
        chk("ra2sel_r31", RBDATA, 32'd0);
        RB = 5'd31; RC = 5'd4; #1;
        chk("ra2sel_rb31", RBDATA, 32'd4);

        RA2SEL = 1'b0; WASEL = 1'b1; WERF = 1'b1; RC = 5'd3; WDATA = 32'h00BC614E; tick();
        WERF = 1'b0; WASEL = 1'b0; RA = 5'd3; #1;
        chk("xp_r3_kept", RADATA, 32'd3);
        RA2SEL = 1'b1; RC = 5'd30; RA = 5'd30; #1;
        chk("xp_a", RADATA, 32'h00BC614E);
        chk("xp_b", RBDATA, 32'h00BC614E);

        // Async reset mid-cycle, then an edge with a write request while held
        @(negedge CLK);
        RA2SEL = 1'b0; RA = 5'd5; RB = 5'd30;
        RST_N = 1'b0; foreach (mdl[i]) mdl[i] = '0; #1;
        chk("arst_a", RADATA, 32'd0);
        chk("arst_b", RBDATA, 32'd0);
        WERF = 1'b1; WASEL = 1'b0; RC = 5'd7; WDATA = 32'hABCD1234;
        tick();
        @(negedge CLK);
        WERF = 1'b0; RST_N = 1'b1; RA = 5'd7; #1;
        chk("arst_wr_block", RADATA, 32'd0);

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            @(negedge CLK);
            RA2SEL = 1'($urandom); WASEL = 1'($urandom_range(0, 4) == 0);
            WERF = 1'($urandom); RA = 5'($urandom); RB = 5'($urandom); RC = 5'($urandom);
            WDATA = $urandom;
            chk_both("rnd_pre");
            tick();
            chk_both("rnd_post");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
